// File: rtl/bp_pkg.sv
// Shared branch-prediction definitions: default widths, the queued branch
// entry and the PC-to-table-index mapping used by both predictor and resolver.
package bp_pkg;

  localparam int DEFAULT_PC_W  = 32;
  localparam int DEFAULT_IDX_W = 6;

  // One in-flight branch as recorded at fetch time.
  typedef struct packed {
    logic [DEFAULT_PC_W-1:0] pc;
    logic                    pred;
  } entry_t;

  // Word-aligned PCs: drop the two byte-offset bits, keep the next IDX_W bits.
  function automatic logic [DEFAULT_IDX_W-1:0] pcToIdx(input logic [DEFAULT_PC_W-1:0] pc);
    return pc[DEFAULT_IDX_W+1:2];
  endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/predictor-update bundle for the branch resolve queue.
interface branch_resolve_queue_if #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 6,
  parameter int CNT_W = 3
);
  logic             push_valid;
  logic             push_ready;
  logic [PC_W-1:0]  push_pc;
  logic             push_pred;
  logic             res_valid;
  logic             res_taken;
  logic [PC_W-1:0]  res_target;
  logic             flush;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_index;
  logic             upd_taken;
  logic             mispredict;
  logic [PC_W-1:0]  redirect_pc;
  logic             res_error;
  logic [CNT_W-1:0] count;

  // Pipeline side: fetch, execute and flush source.
  modport master (
    output push_valid, push_pc, push_pred, res_valid, res_taken, res_target, flush,
    input  push_ready, upd_valid, upd_index, upd_taken, mispredict, redirect_pc,
           res_error, count
  );

  // Queue side.
  modport slave (
    input  push_valid, push_pc, push_pred, res_valid, res_taken, res_target, flush,
    output push_ready, upd_valid, upd_index, upd_taken, mispredict, redirect_pc,
           res_error, count
  );
endinterface

// File: rtl/branch_info_fifo.sv
// Circular buffer of in-flight branch entries. Clear wins over push and pop;
// push is ignored when full and pop is ignored when empty.
module branch_info_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  input  logic                     clear,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] cnt_r;
  logic             doPush_s;
  logic             doPop_s;

  // Qualify requests against occupancy.
  always_comb begin
    full     = (cnt_r == CNT_W'(DEPTH));
    empty    = (cnt_r == {CNT_W{1'b0}});
    doPush_s = push & ~full;
    doPop_s  = pop & ~empty;
  end

  assign rdata = mem_r[head_r];
  assign count = cnt_r;

  // Pointer and occupancy bookkeeping; clear collapses the queue to empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_r <= {PTR_W{1'b0}};
      tail_r <= {PTR_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else if (clear) begin
      head_r <= {PTR_W{1'b0}};
      tail_r <= {PTR_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (doPush_s) tail_r <= tail_r + PTR_W'(1);
      if (doPop_s)  head_r <= head_r + PTR_W'(1);
      if (doPush_s & ~doPop_s)      cnt_r <= cnt_r + CNT_W'(1);
      else if (doPop_s & ~doPush_s) cnt_r <= cnt_r - CNT_W'(1);
      else                          cnt_r <= cnt_r;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (doPush_s & ~clear) mem_r[tail_r] <= wdata;
  end
endmodule

// File: rtl/branch_resolve_queue.sv
// In-order branch resolve queue: records fetch predictions, retires them as
// execute resolves, updates the predictor and redirects on mispredicts.
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = DEFAULT_PC_W,
  parameter int IDX_W = DEFAULT_IDX_W
) (
  input logic                    clk,
  input logic                    rstn,
  branch_resolve_queue_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PC_W:0]    headEntry_s;
  logic [PC_W-1:0]  headPc_s;
  logic             headPred_s;
  logic             full_s;
  logic             empty_s;
  logic [CNT_W-1:0] count_s;
  logic             resolve_s;
  logic             kill_s;
  logic             pushAccept_s;
  logic             clear_s;

  logic             updValid_r;
  logic [IDX_W-1:0] updIndex_r;
  logic             updTaken_r;
  logic             mispredict_r;
  logic [PC_W-1:0]  redirectPc_r;
  logic             resError_r;

  branch_info_fifo #(.DEPTH(DEPTH), .W(PC_W + 1)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (pushAccept_s),
    .wdata ({bus.push_pc, bus.push_pred}),
    .pop   (resolve_s),
    .clear (clear_s),
    .rdata (headEntry_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Resolve/kill decode: a wrong-direction resolve kills every younger entry
  // and any push arriving in the same cycle.
  always_comb begin
    headPc_s     = headEntry_s[PC_W:1];
    headPred_s   = headEntry_s[0];
    resolve_s    = bus.res_valid & ~empty_s;
    kill_s       = resolve_s & (bus.res_taken != headPred_s);
    pushAccept_s = bus.push_valid & ~full_s & ~bus.flush & ~kill_s;
    clear_s      = bus.flush | kill_s;
  end

  // Registered predictor update, redirect and error pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      updValid_r   <= 1'b0;
      updIndex_r   <= {IDX_W{1'b0}};
      updTaken_r   <= 1'b0;
      mispredict_r <= 1'b0;
      redirectPc_r <= {PC_W{1'b0}};
      resError_r   <= 1'b0;
    end else begin
      updValid_r   <= resolve_s;
      mispredict_r <= kill_s;
      resError_r   <= bus.res_valid & empty_s;
      if (resolve_s) begin
        updIndex_r <= headPc_s[IDX_W+1:2];
        updTaken_r <= bus.res_taken;
      end
      if (kill_s) begin
        redirectPc_r <= bus.res_taken ? bus.res_target : (headPc_s + PC_W'(4));
      end
    end
  end

  assign bus.push_ready  = ~full_s;
  assign bus.count       = count_s;
  assign bus.upd_valid   = updValid_r;
  assign bus.upd_index   = updIndex_r;
  assign bus.upd_taken   = updTaken_r;
  assign bus.mispredict  = mispredict_r;
  assign bus.redirect_pc = redirectPc_r;
  assign bus.res_error   = resError_r;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue with a reference queue
// model and a scoreboard of expected predictor updates.
module tb_branch_resolve_queue;
  import bp_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [5:0]  idx;
    logic        taken;
    logic        misp;
    logic [31:0] redir;
  } exp_t;

  logic clk;
  logic rstn;
  int   totalCnt;
  int   passCnt;
  int   failCnt;

  entry_t      model[$];
  exp_t        expQ[$];
  logic [31:0] expRedirect;

  branch_resolve_queue_if #(.PC_W(32), .IDX_W(6), .CNT_W(3)) bus ();

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(32), .IDX_W(6)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    chk({tag, ".count"},       64'(bus.count), 64'd0);
    chk({tag, ".push_ready"},  64'(bus.push_ready), 64'd1);
    chk({tag, ".upd_valid"},   64'(bus.upd_valid), 64'd0);
    chk({tag, ".upd_index"},   64'(bus.upd_index), 64'd0);
    chk({tag, ".upd_taken"},   64'(bus.upd_taken), 64'd0);
    chk({tag, ".mispredict"},  64'(bus.mispredict), 64'd0);
    chk({tag, ".redirect_pc"}, 64'(bus.redirect_pc), 64'd0);
    chk({tag, ".res_error"},   64'(bus.res_error), 64'd0);
  endtask

  // One clock of stimulus: update the model, drive, then check outputs #1 after the edge.
  task automatic step(input string tag, input logic pv, input logic [31:0] ppc,
                      input logic ppred, input logic rv, input logic rt,
                      input logic [31:0] rtgt, input logic fl);
    bit     res, kill, acc, err;
    entry_t h;
    exp_t   e;
    exp_t   got;
    res  = rv && (model.size() > 0);
    kill = 1'b0;
    acc  = 1'b0;
    err  = rv && (model.size() == 0);
    if (res) begin
      h       = model[0];
      kill    = (rt != h.pred);
      e.idx   = h.pc[7:2];
      e.taken = rt;
      e.misp  = kill;
      e.redir = kill ? (rt ? rtgt : h.pc + 32'd4) : expRedirect;
      expQ.push_back(e);
      if (kill) expRedirect = e.redir;
      void'(model.pop_front());
    end
    acc = pv && (model.size() + (res ? 1 : 0) < DEPTH) && !fl && !kill;
    if (fl || kill) model.delete();
    if (acc) model.push_back('{pc: ppc, pred: ppred});

    bus.push_valid = pv;
    bus.push_pc    = ppc;
    bus.push_pred  = ppred;
    bus.res_valid  = rv;
    bus.res_taken  = rt;
    bus.res_target = rtgt;
    bus.flush      = fl;
    @(posedge clk);
    #1;
    chk({tag, ".upd_valid"},   64'(bus.upd_valid), 64'(res));
    chk({tag, ".mispredict"},  64'(bus.mispredict), 64'(res && kill));
    chk({tag, ".res_error"},   64'(bus.res_error), 64'(err));
    chk({tag, ".redirect_pc"}, 64'(bus.redirect_pc), 64'(expRedirect));
    chk({tag, ".count"},       64'(bus.count), 64'(model.size()));
    chk({tag, ".push_ready"},  64'(bus.push_ready), 64'(model.size() < DEPTH));
    if (bus.upd_valid) begin
      if (expQ.size() == 0) begin
        chk({tag, ".unexpected_update"}, 64'd1, 64'd0);
      end else begin
        got = expQ.pop_front();
        chk({tag, ".upd_index"}, 64'(bus.upd_index), 64'(got.idx));
        chk({tag, ".upd_taken"}, 64'(bus.upd_taken), 64'(got.taken));
      end
    end
  endtask

  task automatic push(input string tag, input logic [31:0] pc, input logic pred);
    step(tag, 1'b1, pc, pred, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic resolve(input string tag, input logic taken, input logic [31:0] tgt);
    step(tag, 1'b0, 32'd0, 1'b0, 1'b1, taken, tgt, 1'b0);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    totalCnt    = 0;
    passCnt     = 0;
    failCnt     = 0;
    expRedirect = 32'd0;
    rstn = 1'b0;
    bus.push_valid = 1'b0; bus.push_pc = 32'd0; bus.push_pred = 1'b0;
    bus.res_valid  = 1'b0; bus.res_taken = 1'b0; bus.res_target = 32'd0;
    bus.flush      = 1'b0;
    #1;
    checkIdle("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle("post_reset");

    // Correctly predicted taken branch.
    push("t1_push", 32'h100, 1'b1);
    resolve("t1_res", 1'b1, 32'h200);

    // Predicted taken, actually not taken: redirect to fall-through.
    push("t2_push", 32'h104, 1'b1);
    resolve("t2_res", 1'b0, 32'h300);
    chk("t2.redirect", 64'(bus.redirect_pc), 64'h108);
    chk("t2.mispredict", 64'(bus.mispredict), 64'd1);
    idle("t2_idle");

    // Fill, then push while full alongside a correct resolve: push rejected.
    push("t3_p0", 32'h10, 1'b0);
    push("t3_p1", 32'h14, 1'b0);
    push("t3_p2", 32'h18, 1'b0);
    push("t3_p3", 32'h1C, 1'b0);
    chk("t3.full_ready", 64'(bus.push_ready), 64'd0);
    step("t3_full_push", 1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("t3.count", 64'(bus.count), 64'd3);

    // Mispredict on head with simultaneous push: everything discarded.
    step("t4_kill", 1'b1, 32'h30, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0);
    chk("t4.redirect", 64'(bus.redirect_pc), 64'h400);
    chk("t4.count", 64'(bus.count), 64'd0);
    resolve("t4_empty_res", 1'b1, 32'h500);
    chk("t4.res_error", 64'(bus.res_error), 64'd1);
    idle("t4_idle");

    // Flush with a correct resolve of the head in the same cycle.
    push("t5_p0", 32'h50, 1'b1);
    push("t5_p1", 32'h54, 1'b1);
    step("t5_flush", 1'b1, 32'h58, 1'b0, 1'b1, 1'b1, 32'h600, 1'b1);
    chk("t5.count", 64'(bus.count), 64'd0);
    idle("t5_idle");

    // Wrap pointers: three fill/drain rounds with alternating outcomes.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        push($sformatf("wrap_p%0d_%0d", r, k), 32'h1000 + 32'((r * DEPTH + k) * 4), 1'(k % 2));
      end
      for (int k = 0; k < DEPTH; k++) begin
        resolve($sformatf("wrap_r%0d_%0d", r, k), 1'(k % 2), 32'h2000);
      end
    end

    // Asynchronous reset in the middle of traffic.
    push("ar_p0", 32'h3000, 1'b0);
    push("ar_p1", 32'h3004, 1'b1);
    resolve("ar_mis", 1'b1, 32'h7000);
    push("ar_p2", 32'h3008, 1'b0);
    push("ar_p3", 32'h300C, 1'b0);
    step("ar_res", 1'b1, 32'h3010, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    bus.push_valid = 1'b0;
    bus.res_valid  = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checkIdle("async_reset");
    model.delete();
    expQ.delete();
    expRedirect = 32'd0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    push("rec_push", 32'h44, 1'b0);
    resolve("rec_res", 1'b0, 32'd0);

    chk("scoreboard_empty", 64'(expQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Resolution-side partner of the 2-bit saturating-counter predictor.
- Fetch pushes each conditional branch's PC and predicted direction into an in-order queue.
- Execute resolves branches in program order. For each resolved branch the block pops the oldest entry and drives the counter-table update (index, taken).
- On a wrong prediction it raises a mispredict, supplies the redirect PC and discards all younger entries.

Parameters:
- DEPTH, 4, number of in-flight branch entries; power of two, ≥2.
- PC_W, 32, program-counter width.
- IDX_W, 6, predictor-table index width; index = pc[IDX_W+1:2].

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous, active-low reset.
- push_valid  input  1  fetch presents a predicted branch.
- push_ready  output  1  queue can accept; = ~full, independent of the same-cycle pop.
- push_pc  input  PC_W  branch instruction PC.
- push_pred  input  1  predicted direction (predictor MSB); 1 = taken.
- res_valid  input  1  execute resolves the oldest outstanding branch.
- res_taken  input  1  actual direction.
- res_target  input  PC_W  computed taken target.
- flush  input  1  external pipeline flush (exception or other redirect).
- upd_valid  output  1  predictor update strobe (the predictor's branch-instruction input).
- upd_index  output  IDX_W  table entry to update.
- upd_taken  output  1  actual outcome (the predictor's branch-taken input).
- mispredict  output  1  one-cycle redirect pulse.
- redirect_pc  output  PC_W  correct next PC, valid with mispredict.
- res_error  output  1  one-cycle pulse: resolve arrived while the queue was empty.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset: queue empty; count=0. upd_valid, upd_index, upd_taken, mispredict, redirect_pc and res_error are all 0. push_ready=1.
- Storage: circular buffer with head (oldest) and tail pointers. Pointers are log2(DEPTH) bits, wrap modulo DEPTH, and the block tracks count explicitly. Each entry holds {pc, pred}.
- Push is accepted when push_valid & push_ready & ~flush & ~kill. Here kill = res_valid & ~empty & (res_taken != head.pred). The entry is written at tail, then tail+1.
- Resolve when res_valid & ~empty: head is popped, then head+1. All outputs below are registered, one cycle after the resolve:
  - upd_valid=1, upd_index=head.pc[IDX_W+1:2], upd_taken=res_taken.
  - If res_taken != head.pred: mispredict=1. redirect_pc = res_target if res_taken, else head.pc+4 (modulo 2^PC_W). Every remaining entry is cleared (count=0, head=tail), and a same-cycle push is dropped.
  - Otherwise mispredict=0 and redirect_pc holds its previous value.
- Resolve when empty: no pop, upd_valid=0, res_error=1 on the next cycle. State is otherwise unchanged.
- Simultaneous push and correct resolve: both happen and count is unchanged. A push while full is never accepted, even when a pop occurs in the same cycle.
- flush: clears the queue next edge (count=0, pointers equal) and drops any same-cycle push.
  - A same-cycle valid resolve is still honoured: update issued, mispredict computed as normal. The oldest branch is architecturally resolved.
  - flush has priority over entry retention only.
- upd_valid, mispredict and res_error are single-cycle pulses; each deasserts the cycle after unless re-triggered.
- Asynchronous reset mid-operation discards all entries immediately and forces every output to its reset value.

Decomposition:
- Shared package bp_pkg holds:
  - PC_W and IDX_W defaults;
  - the entry struct {pc, pred};
  - the index-extraction function pc→idx, reused by the predictor table.
- Sub-module branch_info_fifo: a parameterised circular buffer with push, pop, clear, full, empty and count, with clear taking priority.
- Mispredict, update and redirect logic stay in the top level.

Test Plan:
- Reset, push pc=0x100 pred=1, then next cycle resolve taken=1 target=0x200 → 1 cycle later upd_valid=1, upd_index=0x00, upd_taken=1, mispredict=0, count=0.
- Push pc=0x104 pred=1, resolve taken=0 → mispredict=1, redirect_pc=0x108, upd_index=0x01, upd_taken=0.
- Push 0x10,0x14,0x18,0x1C (pred=0) → count=4, push_ready=0; push 0x20 with a correct resolve of 0x10 in the same cycle → push rejected, count=3.
- Queue holds 3 entries; mispredicting resolve of the head (pred=0, taken=1, target=0x400) with a simultaneous push → mispredict=1, redirect_pc=0x400, count=0, pushed entry absent. The next resolve raises res_error=1.
- Push 2 entries, then assert flush with a correct resolve in the same cycle → upd_valid=1 for the head, count=0.
- Fill/drain 3×DEPTH entries with alternating outcomes → pointers wrap correctly and the upd_index sequence matches push order. Assert rstn low mid-stream → count=0 and all outputs 0 immediately.
